// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder
//   Measures the high time of a hobby-servo pulse train in microseconds and
//   converts it to a 0..180 angle code.
//
//   Ports:
//     clk        system clock
//     rstn       asynchronous, active-low reset
//     pwm_in     asynchronous servo pulse input
//     pulse_us   last accepted width in us, clamped to [MIN_US, MAX_US]
//     angle      last accepted angle code, 0..180
//     valid      one-cycle strobe: pulse_us/angle updated this cycle
//     pulse_err  one-cycle strobe: pulse rejected (too short or too long)
//     lost       level: no filtered rising edge within TIMEOUT_US
//     state_dbg  current measurement FSM state (debug)
//
//   Output strobes: valid and pulse_err are registered, mutually exclusive
//   and high for exactly one cycle; there is no back-pressure.
module servo_pwm_decoder #(
    parameter int CLK_PER_US = 50,
    parameter int MIN_US     = 500,
    parameter int MAX_US     = 2500,
    parameter int TOL_US     = 100,
    parameter int GLITCH_CYC = 8,
    parameter int TIMEOUT_US = 25000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pwm_in,
    output logic [11:0] pulse_us,
    output logic [7:0]  angle,
    output logic        valid,
    output logic        pulse_err,
    output logic        lost,
    output logic [1:0]  state_dbg
);

    localparam int PRESC_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int GW      = $clog2(GLITCH_CYC + 1);
    localparam int SPAN    = MAX_US - MIN_US;
    localparam int RW      = $clog2(SPAN + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_US - 1);
    localparam logic [GW-1:0]      GLITCH_LAST = GW'(GLITCH_CYC - 1);
    localparam logic [11:0] LIMIT   = 12'(MAX_US + TOL_US + 1);
    localparam logic [11:0] MIN_ACC = 12'(MIN_US - TOL_US);
    localparam logic [11:0] MIN12   = 12'(MIN_US);
    localparam logic [11:0] MAX12   = 12'(MAX_US);
    localparam logic [18:0] MIN19   = 19'(MIN_US);
    localparam logic [RW:0] SPAN_D  = (RW + 1)'(SPAN);
    localparam logic [20:0] LOST_AT = 21'(TIMEOUT_US * CLK_PER_US - 1);

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2,
        CALC      = 2'd3
    } state_t;

    state_t state, state_n;

    // ---------------- input path ----------------
    logic          s1, s2;
    logic [1:0]    settle;
    logic [GW-1:0] gcnt;
    logic          fin, fin_d;
    logic          rise, fall;

    // settle fills with ones once the synchronizer holds real pin samples;
    // until then the post-reset zeros in s1/s2/fin say nothing about the pin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            settle <= 2'b00;
        end else begin
            s1     <= pwm_in;
            s2     <= s1;
            settle <= {settle[0], 1'b1};
        end
    end

    // fin follows s2 only after GLITCH_CYC consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gcnt  <= '0;
            fin   <= 1'b0;
            fin_d <= 1'b0;
        end else begin
            fin_d <= fin;
            if (s2 != fin) begin
                if (gcnt == GLITCH_LAST) begin
                    fin  <= s2;
                    gcnt <= '0;
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
            end else begin
                gcnt <= '0;
            end
        end
    end

    assign rise = fin & ~fin_d;
    assign fall = ~fin & fin_d;

    // ---------------- measurement datapath signals ----------------
    logic [PRESC_W-1:0] presc;
    logic [11:0]        w, w_next, wc, w_clamp;
    logic               wrap;
    logic [18:0]        num;
    logic [RW-1:0]      rem;
    logic [RW:0]        trial, diff;
    logic               qbit;
    logic [7:0]         quo;
    logic [4:0]         step;
    logic               valid_n, err_n;

    // w_next includes the current cycle, so at the falling edge it equals
    // floor(k / CLK_PER_US) with k the full cycle count between edges.
    assign wrap    = (presc == PRESC_LAST);
    assign w_next  = w + {11'd0, wrap};
    assign w_clamp = (w_next < MIN12) ? MIN12 : ((w_next > MAX12) ? MAX12 : w_next);

    assign trial = {rem, num[18]};
    assign diff  = trial - SPAN_D;
    assign qbit  = (trial >= SPAN_D);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= WAIT_LOW;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            WAIT_LOW: begin
                // Wait until the line is genuinely low so a pulse already in
                // flight (after reset or an abort) is never measured.
                if (settle[1] && !fin && !s2) state_n = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) state_n = HIGH;
            end
            HIGH: begin
                if (w == LIMIT) begin
                    err_n   = 1'b1;
                    state_n = WAIT_LOW;
                end else if (fall) begin
                    if ((w_next < MIN_ACC) || (w_next >= LIMIT)) begin
                        err_n   = 1'b1;
                        state_n = WAIT_RISE;
                    end else begin
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                if (step == 5'd19) begin
                    valid_n = 1'b1;
                    state_n = fin ? WAIT_LOW : WAIT_RISE;
                end
            end
            default: state_n = WAIT_LOW;
        endcase
    end

    assign state_dbg = state;

    // ---------------- width counter, multiply, divide ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc <= '0;
            w     <= '0;
            wc    <= '0;
            num   <= '0;
            rem   <= '0;
            quo   <= '0;
            step  <= '0;
        end else begin
            case (state)
                WAIT_RISE: begin
                    if (rise) begin
                        presc <= '0;
                        w     <= '0;
                    end
                end
                HIGH: begin
                    presc <= wrap ? '0 : presc + 1'b1;
                    w     <= w_next;
                    step  <= '0;
                    if (fall) wc <= w_clamp;
                end
                CALC: begin
                    if (step == 5'd0) begin
                        num <= ({7'd0, wc} - MIN19) * 19'd180;
                        rem <= '0;
                        quo <= '0;
                    end else begin
                        // Restoring division by (MAX_US - MIN_US), MSB first.
                        rem <= qbit ? diff[RW-1:0] : trial[RW-1:0];
                        quo <= {quo[6:0], qbit};
                        num <= {num[17:0], 1'b0};
                    end
                    step <= step + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pulse_us  <= '0;
            angle     <= '0;
            valid     <= 1'b0;
            pulse_err <= 1'b0;
        end else begin
            valid     <= valid_n;
            pulse_err <= err_n;
            if (valid_n) begin
                pulse_us <= wc;
                angle    <= {quo[6:0], qbit};
            end
        end
    end

    // ---------------- loss detection ----------------
    // lcnt = cycles since the last filtered rise (saturating); lost asserts
    // exactly TIMEOUT_US*CLK_PER_US cycles after that rise. A valid strobe
    // clears lost and wins over a coincident timeout.
    logic [20:0] lcnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lcnt <= '0;
            lost <= 1'b1;
        end else begin
            if (rise)              lcnt <= 21'd1;
            else if (lcnt != '1)   lcnt <= lcnt + 1'b1;

            if (valid_n)                lost <= 1'b0;
            else if (lcnt == LOST_AT)   lost <= 1'b1;
        end
    end

endmodule
